soft_body_scheduler: RTL and testbench
======================================

Name: soft_body_scheduler

Overview:
- Time-multiplexes one shared soft-body updater (wheel or body) across NUM_CHANNELS independent soft bodies.
- Holds the per-channel node position/velocity state and an axle force latch for each channel.
- Per frame, launches the updater once per enabled channel, in index order. It serves channel data to the updater and writes back the streamed results.
- Pulses frame_done when the last channel finishes. It replaces fixed two-wheel sequencing with a parametrised, maskable, error-checked scheduler.

Parameters:
NUM_CHANNELS, 3, number of soft bodies sharing the updater (>=1)
NUM_NODES, 16, nodes per channel (>=2)
POSITION_SIZE, 16, signed position width
VELOCITY_SIZE, 16, signed velocity width
FORCE_SIZE, 16, signed axle force width
TIMEOUT_CYCLES, 4096, watchdog limit, used only with SCHED_WATCHDOG_EN

Ports:
clk_in  input  1  clock
rst_in  input  1  asynchronous active-high reset
init_in  input  1  pulse: load ideal shape plus per-channel offsets into the state arrays
ideal_in  input  2xNUM_NODESxPOSITION_SIZE  ideal node shape [x/y][node]
offset_in  input  2xNUM_CHANNELSxPOSITION_SIZE  per-channel placement offset
start_in  input  1  pulse: begin a frame
chan_mask_in  input  NUM_CHANNELS  enabled channels, sampled at start_in
upd_begin_out  output  1  one-cycle launch pulse to the updater
upd_chan_out  output  $clog2(NUM_CHANNELS)+1  channel currently served
rd_idx_in  input  $clog2(NUM_NODES)+1  updater read index
rd_node_x_out/rd_node_y_out  output  POSITION_SIZE  combinational node read, current channel
rd_vel_x_out/rd_vel_y_out  output  VELOCITY_SIZE  combinational velocity read
node_wr_valid_in  input  1  streamed new node
node_wr_x_in/node_wr_y_in  input  POSITION_SIZE  new node value
vel_wr_valid_in  input  1  streamed new velocity
vel_wr_x_in/vel_wr_y_in  input  VELOCITY_SIZE  new velocity value
axle_valid_in  input  1  axle force valid
axle_fx_in/axle_fy_in  input  FORCE_SIZE  axle force
result_in  input  1  updater finished the current channel
axle_fx_out/axle_fy_out  output  NUM_CHANNELSxFORCE_SIZE  latched axle force per channel
node_mon_valid_out  output  1  registered echo of each accepted node write
node_mon_x_out/node_mon_y_out  output  POSITION_SIZE  echoed value
node_mon_chan_out  output  $clog2(NUM_CHANNELS)+1  channel of echo
chan_done_out  output  NUM_CHANNELS  sticky per-frame completion flags
frame_done_out  output  1  one-cycle pulse at end of frame
busy_out  output  1  high from start acceptance to frame_done
err_overflow_out  output  1  sticky: a write beyond NUM_NODES was seen
err_short_out  output  1  sticky: result_in arrived with write count != NUM_NODES

Behaviour:
- Reset (async):
  - State arrays, axle latches, counters and all outputs go to 0.
  - FSM goes to IDLE.
  - Error flags clear.
- init_in (synchronous, IDLE only; ignored otherwise):
  - node[c][k] = ideal[k] + offset[c], with wrapping add at POSITION_SIZE.
  - All velocities become 0.
- IDLE:
  - start_in latches chan_mask_in, clears chan_done_out, and goes to SEEK.
  - start_in while busy is ignored.
- SEEK (1 cycle):
  - Selects the lowest enabled channel not yet served.
  - If one exists: go to LAUNCH. If none: go to DONE.
  - An all-zero mask gives frame_done 2 cycles after start_in.
- LAUNCH (1 cycle):
  - upd_begin_out=1.
  - Clear node and velocity write counters.
  - Go to RUN.
- RUN:
  - Each node_wr_valid_in writes node[chan][node_cnt] and increments node_cnt.
  - Each vel_wr_valid_in does the same for velocities, independently, using vel_cnt.
  - Writes land in the same cycle's state and are visible on the read port next cycle.
  - Any write with its counter == NUM_NODES is dropped and sets err_overflow.
  - axle_valid_in latches the force into the current channel's slot.
  - On result_in:
    - Write counts are checked; if either != NUM_NODES, set err_short.
    - Set chan_done[chan] and go to SEEK.
  - A write and result_in in the same cycle: the write is accepted first and counts toward the check.
- DONE:
  - frame_done_out=1 for one cycle.
  - Go to IDLE; busy_out drops in the same cycle.
- node_mon: registered, one cycle after each accepted node write. Dropped writes are not echoed.
- Read port: purely combinational from the current channel. rd_idx_in >= NUM_NODES returns 0.
- Errors persist until reset or the next start_in.
- Reset mid-frame: immediate return to IDLE with no frame_done. State arrays clear to 0, so init_in is required again.

Optional Feature:
SCHED_WATCHDOG_EN:
- Defined:
  - A RUN-state cycle counter aborts the channel at TIMEOUT_CYCLES with no result_in.
  - On abort: chan_done is left 0, err_timeout_out (extra sticky output, 1 bit) is set, and the FSM goes to SEEK.
- Undefined: no counter and no port; RUN waits indefinitely.

Test Plan:
1. Reset, then init_in with ideal x=k, y=0, offset ch0=(-75,-10), ch1=(75,-10) -> reading ch1 idx 3 gives (78,-10) and velocity 0.
2. Mask 3'b101, start, updater model streams 16 nodes and 16 velocities then result for each channel -> launches on ch0 then ch2 only; chan_done=101; frame_done a single pulse; no errors.
3. 17 node writes on ch0 -> the 17th is dropped, err_overflow=1, node[0][15] keeps the 16th value; the frame still completes.
4. result_in after 10 writes -> err_short=1, chan_done bit set, the next channel launches.
5. Mask 0 -> frame_done exactly 2 cycles after start; upd_begin never asserts.
6. rst_in asserted mid-RUN on ch1 -> outputs 0 in the same cycle; a subsequent start with no init runs normally from zero state. With SCHED_WATCHDOG_EN and TIMEOUT_CYCLES=64 and no result -> err_timeout=1 after 64 RUN cycles.

Source files
------------

// File: rtl/soft_body_scheduler.sv
// soft_body_scheduler: shares one soft-body updater across NUM_CHANNELS bodies, one launch per
// enabled channel per frame. Define SCHED_WATCHDOG_EN to add a RUN timeout and err_timeout_out.
module soft_body_scheduler #(
  parameter int unsigned NUM_CHANNELS   = 3,
  parameter int unsigned NUM_NODES      = 16,
  parameter int unsigned POSITION_SIZE  = 16,
  parameter int unsigned VELOCITY_SIZE  = 16,
  parameter int unsigned FORCE_SIZE     = 16,
  parameter int unsigned TIMEOUT_CYCLES = 4096,
  localparam int unsigned ChanW = $clog2(NUM_CHANNELS) + 1,
  localparam int unsigned IdxW  = $clog2(NUM_NODES) + 1
) (
  input  logic                                                   clk_in,
  input  logic                                                   rst_in,
  input  logic                                                   init_in,
  input  logic [1:0][NUM_NODES-1:0][POSITION_SIZE-1:0]           ideal_in,
  input  logic [1:0][NUM_CHANNELS-1:0][POSITION_SIZE-1:0]        offset_in,
  input  logic                                                   start_in,
  input  logic [NUM_CHANNELS-1:0]                                chan_mask_in,
  output logic                                                   upd_begin_out,
  output logic [ChanW-1:0]                                       upd_chan_out,
  input  logic [IdxW-1:0]                                        rd_idx_in,
  output logic [POSITION_SIZE-1:0]                               rd_node_x_out,
  output logic [POSITION_SIZE-1:0]                               rd_node_y_out,
  output logic [VELOCITY_SIZE-1:0]                               rd_vel_x_out,
  output logic [VELOCITY_SIZE-1:0]                               rd_vel_y_out,
  input  logic                                                   node_wr_valid_in,
  input  logic [POSITION_SIZE-1:0]                               node_wr_x_in,
  input  logic [POSITION_SIZE-1:0]                               node_wr_y_in,
  input  logic                                                   vel_wr_valid_in,
  input  logic [VELOCITY_SIZE-1:0]                               vel_wr_x_in,
  input  logic [VELOCITY_SIZE-1:0]                               vel_wr_y_in,
  input  logic                                                   axle_valid_in,
  input  logic [FORCE_SIZE-1:0]                                  axle_fx_in,
  input  logic [FORCE_SIZE-1:0]                                  axle_fy_in,
  input  logic                                                   result_in,
  output logic [NUM_CHANNELS-1:0][FORCE_SIZE-1:0]                axle_fx_out,
  output logic [NUM_CHANNELS-1:0][FORCE_SIZE-1:0]                axle_fy_out,
  output logic                                                   node_mon_valid_out,
  output logic [POSITION_SIZE-1:0]                               node_mon_x_out,
  output logic [POSITION_SIZE-1:0]                               node_mon_y_out,
  output logic [ChanW-1:0]                                       node_mon_chan_out,
  output logic [NUM_CHANNELS-1:0]                                chan_done_out,
  output logic                                                   frame_done_out,
  output logic                                                   busy_out,
`ifdef SCHED_WATCHDOG_EN
  output logic                                                   err_timeout_out,
`endif
  output logic                                                   err_overflow_out,
  output logic                                                   err_short_out
);

  localparam int unsigned ChanSelW = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;
  localparam int unsigned NodeSelW = $clog2(NUM_NODES);
  localparam logic [IdxW-1:0] NodesMax = IdxW'(NUM_NODES);

  typedef enum logic [2:0] {StIdle, StSeek, StLaunch, StRun, StDone} state_e;

  state_e state_q, state_d;
  logic [NUM_CHANNELS-1:0][NUM_NODES-1:0][POSITION_SIZE-1:0] node_x_q, node_x_d;
  logic [NUM_CHANNELS-1:0][NUM_NODES-1:0][POSITION_SIZE-1:0] node_y_q, node_y_d;
  logic [NUM_CHANNELS-1:0][NUM_NODES-1:0][VELOCITY_SIZE-1:0] vel_x_q, vel_x_d;
  logic [NUM_CHANNELS-1:0][NUM_NODES-1:0][VELOCITY_SIZE-1:0] vel_y_q, vel_y_d;
  logic [NUM_CHANNELS-1:0][FORCE_SIZE-1:0] axle_fx_q, axle_fx_d, axle_fy_q, axle_fy_d;
  logic [NUM_CHANNELS-1:0] mask_q, mask_d, served_q, served_d, chan_done_q, chan_done_d;
  logic [ChanW-1:0]        chan_q, chan_d, mon_chan_q, mon_chan_d;
  logic [IdxW-1:0]         node_cnt_q, node_cnt_d, vel_cnt_q, vel_cnt_d;
  logic                    upd_begin_q, upd_begin_d, frame_done_q, frame_done_d;
  logic                    busy_q, busy_d, err_ovf_q, err_ovf_d, err_short_q, err_short_d;
  logic                    mon_valid_q, mon_valid_d;
  logic [POSITION_SIZE-1:0] mon_x_q, mon_x_d, mon_y_q, mon_y_d;
`ifdef SCHED_WATCHDOG_EN
  localparam int unsigned WdW = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [WdW-1:0] WdLast = WdW'(TIMEOUT_CYCLES - 1);
  logic [WdW-1:0] wd_cnt_q, wd_cnt_d;
  logic           err_timeout_q, err_timeout_d;
`endif

  logic [ChanSelW-1:0] cur;
  logic                seek_found;
  logic [ChanW-1:0]    seek_chan;
  logic [NodeSelW-1:0] node_ptr, vel_ptr;

  assign cur      = chan_q[ChanSelW-1:0];
  assign node_ptr = node_cnt_q[NodeSelW-1:0];
  assign vel_ptr  = vel_cnt_q[NodeSelW-1:0];

  // Downward scan so the lowest pending channel wins.
  always_comb begin
    seek_found = 1'b0;
    seek_chan  = '0;
    for (int i = int'(NUM_CHANNELS) - 1; i >= 0; i--) begin
      if (mask_q[i] && !served_q[i]) begin
        seek_found = 1'b1;
        seek_chan  = ChanW'(i);
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    node_x_d     = node_x_q;
    node_y_d     = node_y_q;
    vel_x_d      = vel_x_q;
    vel_y_d      = vel_y_q;
    axle_fx_d    = axle_fx_q;
    axle_fy_d    = axle_fy_q;
    mask_d       = mask_q;
    served_d     = served_q;
    chan_done_d  = chan_done_q;
    chan_d       = chan_q;
    node_cnt_d   = node_cnt_q;
    vel_cnt_d    = vel_cnt_q;
    upd_begin_d  = 1'b0;
    frame_done_d = 1'b0;
    busy_d       = busy_q;
    err_ovf_d    = err_ovf_q;
    err_short_d  = err_short_q;
    mon_valid_d  = 1'b0;
    mon_x_d      = mon_x_q;
    mon_y_d      = mon_y_q;
    mon_chan_d   = mon_chan_q;
`ifdef SCHED_WATCHDOG_EN
    wd_cnt_d      = wd_cnt_q;
    err_timeout_d = err_timeout_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (init_in) begin
          for (int c = 0; c < int'(NUM_CHANNELS); c++) begin
            for (int k = 0; k < int'(NUM_NODES); k++) begin
              node_x_d[c][k] = ideal_in[0][k] + offset_in[0][c];
              node_y_d[c][k] = ideal_in[1][k] + offset_in[1][c];
            end
          end
          vel_x_d = '0;
          vel_y_d = '0;
        end
        if (start_in) begin
          mask_d      = chan_mask_in;
          served_d    = '0;
          chan_done_d = '0;
          err_ovf_d   = 1'b0;
          err_short_d = 1'b0;
`ifdef SCHED_WATCHDOG_EN
          err_timeout_d = 1'b0;
`endif
          busy_d      = 1'b1;
          state_d     = StSeek;
        end
      end
      StSeek: begin
        if (seek_found) begin
          chan_d                          = seek_chan;
          served_d[seek_chan[ChanSelW-1:0]] = 1'b1;
          upd_begin_d                     = 1'b1;
          state_d                         = StLaunch;
        end else begin
          frame_done_d = 1'b1;
          busy_d       = 1'b0;
          state_d      = StDone;
        end
      end
      StLaunch: begin
        node_cnt_d = '0;
        vel_cnt_d  = '0;
`ifdef SCHED_WATCHDOG_EN
        wd_cnt_d   = '0;
`endif
        state_d    = StRun;
      end
      StRun: begin
        if (node_wr_valid_in) begin
          if (node_cnt_q != NodesMax) begin
            node_x_d[cur][node_ptr] = node_wr_x_in;
            node_y_d[cur][node_ptr] = node_wr_y_in;
            node_cnt_d              = node_cnt_q + IdxW'(1);
            mon_valid_d             = 1'b1;
            mon_x_d                 = node_wr_x_in;
            mon_y_d                 = node_wr_y_in;
            mon_chan_d              = chan_q;
          end else begin
            err_ovf_d = 1'b1;
          end
        end
        if (vel_wr_valid_in) begin
          if (vel_cnt_q != NodesMax) begin
            vel_x_d[cur][vel_ptr] = vel_wr_x_in;
            vel_y_d[cur][vel_ptr] = vel_wr_y_in;
            vel_cnt_d             = vel_cnt_q + IdxW'(1);
          end else begin
            err_ovf_d = 1'b1;
          end
        end
        if (axle_valid_in) begin
          axle_fx_d[cur] = axle_fx_in;
          axle_fy_d[cur] = axle_fy_in;
        end
        // Counts include a write landing in the same cycle as result_in.
        if (result_in) begin
          if (node_cnt_d != NodesMax || vel_cnt_d != NodesMax) err_short_d = 1'b1;
          chan_done_d[cur] = 1'b1;
          state_d          = StSeek;
        end
`ifdef SCHED_WATCHDOG_EN
        else if (wd_cnt_q == WdLast) begin
          err_timeout_d = 1'b1;
          state_d       = StSeek;
        end else begin
          wd_cnt_d = wd_cnt_q + WdW'(1);
        end
`endif
      end
      StDone: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q      <= StIdle;
      node_x_q     <= '0;
      node_y_q     <= '0;
      vel_x_q      <= '0;
      vel_y_q      <= '0;
      axle_fx_q    <= '0;
      axle_fy_q    <= '0;
      mask_q       <= '0;
      served_q     <= '0;
      chan_done_q  <= '0;
      chan_q       <= '0;
      node_cnt_q   <= '0;
      vel_cnt_q    <= '0;
      upd_begin_q  <= 1'b0;
      frame_done_q <= 1'b0;
      busy_q       <= 1'b0;
      err_ovf_q    <= 1'b0;
      err_short_q  <= 1'b0;
      mon_valid_q  <= 1'b0;
      mon_x_q      <= '0;
      mon_y_q      <= '0;
      mon_chan_q   <= '0;
`ifdef SCHED_WATCHDOG_EN
      wd_cnt_q      <= '0;
      err_timeout_q <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      node_x_q     <= node_x_d;
      node_y_q     <= node_y_d;
      vel_x_q      <= vel_x_d;
      vel_y_q      <= vel_y_d;
      axle_fx_q    <= axle_fx_d;
      axle_fy_q    <= axle_fy_d;
      mask_q       <= mask_d;
      served_q     <= served_d;
      chan_done_q  <= chan_done_d;
      chan_q       <= chan_d;
      node_cnt_q   <= node_cnt_d;
      vel_cnt_q    <= vel_cnt_d;
      upd_begin_q  <= upd_begin_d;
      frame_done_q <= frame_done_d;
      busy_q       <= busy_d;
      err_ovf_q    <= err_ovf_d;
      err_short_q  <= err_short_d;
      mon_valid_q  <= mon_valid_d;
      mon_x_q      <= mon_x_d;
      mon_y_q      <= mon_y_d;
      mon_chan_q   <= mon_chan_d;
`ifdef SCHED_WATCHDOG_EN
      wd_cnt_q      <= wd_cnt_d;
      err_timeout_q <= err_timeout_d;
`endif
    end
  end

  always_comb begin
    rd_node_x_out = '0;
    rd_node_y_out = '0;
    rd_vel_x_out  = '0;
    rd_vel_y_out  = '0;
    if (rd_idx_in < NodesMax) begin
      rd_node_x_out = node_x_q[cur][rd_idx_in[NodeSelW-1:0]];
      rd_node_y_out = node_y_q[cur][rd_idx_in[NodeSelW-1:0]];
      rd_vel_x_out  = vel_x_q[cur][rd_idx_in[NodeSelW-1:0]];
      rd_vel_y_out  = vel_y_q[cur][rd_idx_in[NodeSelW-1:0]];
    end
  end

  assign upd_begin_out      = upd_begin_q;
  assign upd_chan_out       = chan_q;
  assign axle_fx_out        = axle_fx_q;
  assign axle_fy_out        = axle_fy_q;
  assign node_mon_valid_out = mon_valid_q;
  assign node_mon_x_out     = mon_x_q;
  assign node_mon_y_out     = mon_y_q;
  assign node_mon_chan_out  = mon_chan_q;
  assign chan_done_out      = chan_done_q;
  assign frame_done_out     = frame_done_q;
  assign busy_out           = busy_q;
  assign err_overflow_out   = err_ovf_q;
  assign err_short_out      = err_short_q;
`ifdef SCHED_WATCHDOG_EN
  assign err_timeout_out    = err_timeout_q;
`endif

endmodule

// File: tb/tb_soft_body_scheduler.sv
// Directed bench for soft_body_scheduler: launch order and node echoes are checked against
// scoreboard queues filled as stimulus is driven.
module tb_soft_body_scheduler;
  localparam int NC = 3;
  localparam int NN = 16;
  localparam int PS = 16;
  localparam int CW = $clog2(NC) + 1;
  localparam int IW = $clog2(NN) + 1;

  logic clk, rst, init, start, upd_begin, node_wr_valid, vel_wr_valid, axle_valid, result;
  logic [1:0][NN-1:0][PS-1:0] ideal;
  logic [1:0][NC-1:0][PS-1:0] offset;
  logic [NC-1:0] mask, chan_done;
  logic [CW-1:0] upd_chan, mon_chan;
  logic [IW-1:0] rd_idx;
  logic [PS-1:0] rd_x, rd_y, rd_vx, rd_vy, wr_x, wr_y, wr_vx, wr_vy, axle_fx, axle_fy;
  logic [PS-1:0] mon_x, mon_y;
  logic [NC-1:0][PS-1:0] axle_fx_o, axle_fy_o;
  logic mon_valid, frame_done, busy, err_ovf, err_short;
`ifdef SCHED_WATCHDOG_EN
  logic err_timeout;
`endif

  int n_checks = 0;
  int n_fail = 0;
  logic [CW-1:0] launch_q[$];
  logic [CW+2*PS-1:0] mon_q[$];

  soft_body_scheduler #(.NUM_CHANNELS(NC), .NUM_NODES(NN), .POSITION_SIZE(PS),
    .VELOCITY_SIZE(PS), .FORCE_SIZE(PS), .TIMEOUT_CYCLES(64)) dut (
    .clk_in(clk), .rst_in(rst), .init_in(init), .ideal_in(ideal), .offset_in(offset),
    .start_in(start), .chan_mask_in(mask), .upd_begin_out(upd_begin), .upd_chan_out(upd_chan),
    .rd_idx_in(rd_idx), .rd_node_x_out(rd_x), .rd_node_y_out(rd_y), .rd_vel_x_out(rd_vx),
    .rd_vel_y_out(rd_vy), .node_wr_valid_in(node_wr_valid), .node_wr_x_in(wr_x),
    .node_wr_y_in(wr_y), .vel_wr_valid_in(vel_wr_valid), .vel_wr_x_in(wr_vx),
    .vel_wr_y_in(wr_vy), .axle_valid_in(axle_valid), .axle_fx_in(axle_fx),
    .axle_fy_in(axle_fy), .result_in(result), .axle_fx_out(axle_fx_o), .axle_fy_out(axle_fy_o),
    .node_mon_valid_out(mon_valid), .node_mon_x_out(mon_x), .node_mon_y_out(mon_y),
    .node_mon_chan_out(mon_chan), .chan_done_out(chan_done), .frame_done_out(frame_done),
    .busy_out(busy),
`ifdef SCHED_WATCHDOG_EN
    .err_timeout_out(err_timeout),
`endif
    .err_overflow_out(err_ovf), .err_short_out(err_short));

  always #5 clk = ~clk;

  function automatic logic [PS-1:0] nx(input int s, input int i);
    return PS'(s * 97 + i * 3 + 5);
  endfunction
  function automatic logic [PS-1:0] ny(input int s, input int i);
    return PS'(s * 13 - i * 7);
  endfunction

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock and score any launch or node echo the DUT produced.
  task automatic cycle();
    logic [CW+2*PS-1:0] e;
    logic [CW-1:0] lc;
    @(posedge clk);
    #1;
    if (upd_begin) begin
      if (launch_q.size() == 0) chk("unexpected_launch", 16'(upd_begin), 16'd0);
      else begin
        lc = launch_q.pop_front();
        chk("launch_chan", 16'(upd_chan), 16'(lc));
      end
    end
    if (mon_valid) begin
      if (mon_q.size() == 0) chk("unexpected_mon", 16'(mon_valid), 16'd0);
      else begin
        e = mon_q.pop_front();
        chk("mon_x", mon_x, e[2*PS-1:PS]);
        chk("mon_y", mon_y, e[PS-1:0]);
        chk("mon_chan", 16'(mon_chan), 16'(e[CW+2*PS-1:2*PS]));
      end
    end
  endtask

  task automatic wait_begin();
    int t = 0;
    while (!upd_begin && t < 20) begin
      cycle();
      t++;
    end
    chk("begin_seen", 16'(upd_begin), 16'd1);
    cycle();
  endtask

  task automatic wait_done();
    int t = 0;
    while (!frame_done && t < 20) begin
      cycle();
      t++;
    end
    chk("frame_done_seen", 16'(frame_done), 16'd1);
    chk("busy_at_done", 16'(busy), 16'd0);
    cycle();
    chk("frame_done_pulse", 16'(frame_done), 16'd0);
  endtask

  task automatic stream(input int chan, input int n_node, input int n_vel, input int seed,
                        input bit last_res);
    int n = (n_node > n_vel) ? n_node : n_vel;
    for (int i = 0; i < n; i++) begin
      node_wr_valid = (i < n_node);
      vel_wr_valid  = (i < n_vel);
      wr_x  = nx(seed, i);
      wr_y  = ny(seed, i);
      wr_vx = ~nx(seed, i);
      wr_vy = nx(seed, i) ^ 16'h0f0f;
      if (i < n_node && i < NN) mon_q.push_back({CW'(chan), nx(seed, i), ny(seed, i)});
      result = last_res && (i == n - 1);
      cycle();
    end
    node_wr_valid = 1'b0;
    vel_wr_valid  = 1'b0;
    result        = 1'b0;
  endtask

  task automatic finish_chan();
    result = 1'b1;
    cycle();
    result = 1'b0;
  endtask

  task automatic start_frame(input logic [NC-1:0] m);
    mask  = m;
    start = 1'b1;
    cycle();
    start = 1'b0;
  endtask

  initial begin
    clk = 0; rst = 0; init = 0; start = 0; mask = '0; rd_idx = '0;
    node_wr_valid = 0; vel_wr_valid = 0; axle_valid = 0; result = 0;
    wr_x = '0; wr_y = '0; wr_vx = '0; wr_vy = '0; axle_fx = '0; axle_fy = '0;
    for (int k = 0; k < NN; k++) begin
      ideal[0][k] = PS'(k);
      ideal[1][k] = '0;
    end
    offset[0][0] = -16'sd75;  offset[1][0] = -16'sd10;
    offset[0][1] = 16'sd75;   offset[1][1] = -16'sd10;
    offset[0][2] = 16'sd300;  offset[1][2] = 16'sd40;

    // Reset state
    #3 rst = 1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", 16'(busy), 16'd0);
    chk("rst_frame_done", 16'(frame_done), 16'd0);
    chk("rst_chan_done", 16'(chan_done), 16'd0);
    chk("rst_err_ovf", 16'(err_ovf), 16'd0);
    chk("rst_err_short", 16'(err_short), 16'd0);
    chk("rst_upd_begin", 16'(upd_begin), 16'd0);
    chk("rst_rd_x", rd_x, 16'd0);
    rst = 0;
    cycle();

    // Init: ideal + per-channel offset
    init = 1;
    cycle();
    init = 0;
    rd_idx = 5'd3;
    #1;
    chk("init_ch0_x3", rd_x, -16'sd72);
    chk("init_ch0_y3", rd_y, -16'sd10);
    chk("init_ch0_vx3", rd_vx, 16'd0);
    rd_idx = 5'd16;
    #1;
    chk("rd_oob_x", rd_x, 16'd0);

    // Mask 011 with an axle latch on ch1
    launch_q.push_back(CW'(0));
    launch_q.push_back(CW'(1));
    start_frame(3'b011);
    chk("busy_after_start", 16'(busy), 16'd1);
    wait_begin();
    stream(0, 16, 16, 1, 1'b0);
    rd_idx = 5'd0;
    #1;
    chk("rd_written_x0", rd_x, nx(1, 0));
    rd_idx = 5'd5;
    #1;
    chk("rd_written_vx5", rd_vx, ~nx(1, 5));
    finish_chan();
    chk("chan_done_after_ch0", 16'(chan_done), 16'd1);
    wait_begin();
    rd_idx = 5'd3;
    #1;
    chk("init_ch1_x3", rd_x, 16'd78);
    chk("init_ch1_y3", rd_y, -16'sd10);
    chk("init_ch1_vx3", rd_vx, 16'd0);
    axle_valid = 1; axle_fx = 16'd123; axle_fy = -16'sd5;
    cycle();
    axle_valid = 0;
    chk("axle_fx1", axle_fx_o[1], 16'd123);
    chk("axle_fy1", axle_fy_o[1], -16'sd5);
    stream(1, 16, 16, 2, 1'b0);
    finish_chan();
    wait_done();
    chk("chan_done_011", 16'(chan_done), 16'd3);
    chk("err_ovf_011", 16'(err_ovf), 16'd0);
    chk("err_short_011", 16'(err_short), 16'd0);

    // Mask 101; ch2's final write coincides with result_in
    launch_q.push_back(CW'(0));
    launch_q.push_back(CW'(2));
    start_frame(3'b101);
    wait_begin();
    stream(0, 16, 16, 5, 1'b0);
    finish_chan();
    wait_begin();
    stream(2, 16, 16, 6, 1'b1);
    wait_done();
    chk("chan_done_101", 16'(chan_done), 16'd5);
    chk("err_short_101", 16'(err_short), 16'd0);
    chk("err_ovf_101", 16'(err_ovf), 16'd0);

    // Overflow: 17th node write on ch0 is dropped
    launch_q.push_back(CW'(0));
    start_frame(3'b001);
    wait_begin();
    stream(0, 17, 16, 3, 1'b0);
    chk("err_ovf_set", 16'(err_ovf), 16'd1);
    rd_idx = 5'd15;
    #1;
    chk("ovf_keeps_16th", rd_x, nx(3, 15));
    finish_chan();
    wait_done();
    chk("ovf_chan_done", 16'(chan_done), 16'd1);
    chk("ovf_no_short", 16'(err_short), 16'd0);

    // Short: result after 10 writes, next channel still launches
    launch_q.push_back(CW'(0));
    launch_q.push_back(CW'(1));
    start_frame(3'b011);
    chk("start_clears_ovf", 16'(err_ovf), 16'd0);
    wait_begin();
    stream(0, 10, 10, 7, 1'b0);
    finish_chan();
    chk("err_short_set", 16'(err_short), 16'd1);
    chk("short_chan_done", 16'(chan_done), 16'd1);
    wait_begin();
    stream(1, 16, 16, 8, 1'b0);
    finish_chan();
    wait_done();
    chk("short_frame_done_mask", 16'(chan_done), 16'd3);

    // Empty mask: frame_done exactly two cycles after start
    start_frame(3'b000);
    chk("mask0_cycle1_fd", 16'(frame_done), 16'd0);
    chk("mask0_cycle1_busy", 16'(busy), 16'd1);
    cycle();
    chk("mask0_cycle2_fd", 16'(frame_done), 16'd1);
    chk("mask0_cycle2_busy", 16'(busy), 16'd0);
    cycle();
    chk("mask0_cycle3_fd", 16'(frame_done), 16'd0);

    // Reset mid-RUN on ch1
    launch_q.push_back(CW'(1));
    start_frame(3'b010);
    wait_begin();
    stream(1, 5, 5, 9, 1'b0);
    rd_idx = 5'd3;
    rst = 1;
    #1;
    chk("midrst_busy", 16'(busy), 16'd0);
    chk("midrst_chan", 16'(upd_chan), 16'd0);
    chk("midrst_rd_x", rd_x, 16'd0);
    chk("midrst_axle", axle_fx_o[1], 16'd0);
    chk("midrst_mon", 16'(mon_valid), 16'd0);
    chk("midrst_chan_done", 16'(chan_done), 16'd0);
    cycle();
    mon_q.delete();
    launch_q.delete();
    rst = 0;
    cycle();
    launch_q.push_back(CW'(0));
    start_frame(3'b001);
    wait_begin();
    #1;
    chk("zero_state_x3", rd_x, 16'd0);
    chk("zero_state_y3", rd_y, 16'd0);
    stream(0, 16, 16, 10, 1'b0);
    finish_chan();
    wait_done();
    chk("post_rst_chan_done", 16'(chan_done), 16'd1);
    chk("post_rst_short", 16'(err_short), 16'd0);

`ifdef SCHED_WATCHDOG_EN
    // Watchdog: no result for 64 RUN cycles aborts the channel
    launch_q.push_back(CW'(0));
    start_frame(3'b001);
    wait_begin();
    repeat (63) cycle();
    chk("wd_not_yet", 16'(err_timeout), 16'd0);
    cycle();
    chk("wd_fired", 16'(err_timeout), 16'd1);
    wait_done();
    chk("wd_chan_done", 16'(chan_done), 16'd0);
`endif

    chk("mon_q_drained", 16'(mon_q.size()), 16'd0);
    chk("launch_q_drained", 16'(launch_q.size()), 16'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
